// File: rtl/code_lock_ctrl.sv
//------------------------------------------------------------------------------
//+----------------------------------------------------------------------------+
//| Module      : code_lock_ctrl                                               |
//| Description : Parametrised keypad-lock controller. Digits arrive on sw and  |
//|               are committed with ent, then compared against a stored code. |
//|               After a match the code can be replaced via change. Repeated  |
//|               mismatches trigger a timed lockout. Drives the status LEDs   |
//|               and a multiplexed, active-low seven-segment display.         |
//|                                                                            |
//| Ports       : clk_in    - single clock                                     |
//|               rst       - synchronous active-high reset                    |
//|               clr       - clear / abort (debounced level, rising edge)     |
//|               ent       - commit digit  (debounced level, rising edge)     |
//|               change    - request code change (debounced, rising edge)     |
//|               sw        - digit value, DIGIT_W bits                        |
//|               led       - [0] LOCKED [1] OPEN [2] SET [3] ERROR            |
//|                           [4] LOCKOUT [5] entry in progress                |
//|               AN        - digit anodes, active low                         |
//|               seven_out - segments {g,f,e,d,c,b,a}, active low             |
//|                                                                            |
//| Revision    : 1.0 - initial release                                        |
//+----------------------------------------------------------------------------+
`default_nettype none

module code_lock_ctrl #(
    parameter int                             N_DIGITS    = 4,
    parameter int                             DIGIT_W     = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0]    RESET_CODE  = 16'h1234,
    parameter int                             MAX_TRIES   = 3,
    parameter int                             LOCK_CYCLES = 100_000_000,
    parameter int                             REFRESH_DIV = 100_000
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                clr,
    input  logic                ent,
    input  logic                change,
    input  logic [DIGIT_W-1:0]  sw,
    output logic [5:0]          led,
    output logic [N_DIGITS-1:0] AN,
    output logic [6:0]          seven_out
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int c_code_w = N_DIGITS * DIGIT_W;
    localparam int c_ptr_w  = $clog2(N_DIGITS + 1);
    localparam int c_idx_w  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_try_w  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
    localparam int c_lck_w  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int c_ref_w  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(N_DIGITS - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_full  = c_ptr_w'(N_DIGITS);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(N_DIGITS - 1);
    localparam logic [c_try_w-1:0] c_try_last  = c_try_w'(MAX_TRIES - 1);
    localparam logic [c_lck_w-1:0] c_lck_load  = c_lck_w'(LOCK_CYCLES - 1);
    localparam logic [c_ref_w-1:0] c_ref_last  = c_ref_w'(REFRESH_DIV - 1);

    localparam logic [2:0] c_st_locked  = 3'd0;
    localparam logic [2:0] c_st_check   = 3'd1;
    localparam logic [2:0] c_st_open    = 3'd2;
    localparam logic [2:0] c_st_set     = 3'd3;
    localparam logic [2:0] c_st_error   = 3'd4;
    localparam logic [2:0] c_st_lockout = 3'd5;

    localparam logic [6:0] c_seg_blank = 7'h7F;
    localparam logic [6:0] c_seg_dash  = 7'b0111111;

    //--------------------------------------------------------------------------
    // Hex glyph lookup, active-low {g,f,e,d,c,b,a}
    //--------------------------------------------------------------------------
    function automatic logic [6:0] f_hex_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    //--------------------------------------------------------------------------
    // Button edge detection. Each level is registered once into r_*_now and
    // the previous sample is kept in r_*_prev. Clearing both on reset makes a
    // button held through reset produce an edge once reset is released.
    //--------------------------------------------------------------------------
    logic r_clr_now, r_clr_prev;
    logic r_ent_now, r_ent_prev;
    logic r_chg_now, r_chg_prev;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_clr_now  <= 1'b0;
            r_clr_prev <= 1'b0;
            r_ent_now  <= 1'b0;
            r_ent_prev <= 1'b0;
            r_chg_now  <= 1'b0;
            r_chg_prev <= 1'b0;
        end else begin
            r_clr_now  <= clr;
            r_clr_prev <= r_clr_now;
            r_ent_now  <= ent;
            r_ent_prev <= r_ent_now;
            r_chg_now  <= change;
            r_chg_prev <= r_chg_now;
        end
    end

    logic w_clr_raw, w_ent_raw, w_chg_raw;
    logic w_clr_edge, w_ent_edge, w_chg_edge;

    // Coincident edges resolve clr > ent > change; losers are dropped.
    always_comb begin
        w_clr_raw  = r_clr_now & ~r_clr_prev;
        w_ent_raw  = r_ent_now & ~r_ent_prev;
        w_chg_raw  = r_chg_now & ~r_chg_prev;
        w_clr_edge = w_clr_raw;
        w_ent_edge = w_ent_raw & ~w_clr_raw;
        w_chg_edge = w_chg_raw & ~w_clr_raw & ~w_ent_raw;
    end

    //--------------------------------------------------------------------------
    // Control state
    //--------------------------------------------------------------------------
    logic [2:0]          r_state,    w_state_nxt;
    logic [c_code_w-1:0] r_buf,      w_buf_nxt;
    logic [c_ptr_w-1:0]  r_ptr,      w_ptr_nxt;
    logic [c_code_w-1:0] r_code,     w_code_nxt;
    logic [c_try_w-1:0]  r_tries,    w_tries_nxt;
    logic [c_lck_w-1:0]  r_lock_cnt, w_lock_cnt_nxt;

    // Entry buffer with sw written into slot r_ptr; slot 0 is the MS digit.
    logic [c_code_w-1:0] w_buf_wr;

    always_comb begin
        w_buf_wr = r_buf;
        for (int s = 0; s < N_DIGITS; s++) begin
            if (r_ptr == c_ptr_w'(s)) begin
                w_buf_wr[(N_DIGITS-1-s)*DIGIT_W +: DIGIT_W] = sw;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= c_st_locked;
            r_buf      <= '0;
            r_ptr      <= '0;
            r_code     <= RESET_CODE;
            r_tries    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_buf      <= w_buf_nxt;
            r_ptr      <= w_ptr_nxt;
            r_code     <= w_code_nxt;
            r_tries    <= w_tries_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_buf_nxt      = r_buf;
        w_ptr_nxt      = r_ptr;
        w_code_nxt     = r_code;
        w_tries_nxt    = r_tries;
        w_lock_cnt_nxt = r_lock_cnt;

        case (r_state)
            c_st_locked: begin
                if (w_clr_edge) begin
                    w_buf_nxt = '0;
                    w_ptr_nxt = '0;
                end else if (w_ent_edge) begin
                    w_buf_nxt = w_buf_wr;
                    w_ptr_nxt = r_ptr + c_ptr_w'(1);
                    if (r_ptr == c_ptr_last) begin
                        w_ptr_nxt   = c_ptr_full;
                        w_state_nxt = c_st_check;
                    end
                end
            end

            c_st_check: begin
                w_buf_nxt = '0;
                w_ptr_nxt = '0;
                if (r_buf == r_code) begin
                    w_state_nxt = c_st_open;
                    w_tries_nxt = '0;
                end else begin
                    w_tries_nxt = r_tries + c_try_w'(1);
                    if (r_tries == c_try_last) begin
                        w_state_nxt    = c_st_lockout;
                        w_lock_cnt_nxt = c_lck_load;
                    end else begin
                        w_state_nxt = c_st_error;
                    end
                end
            end

            // The dismissing ent edge is consumed here; it stores no digit.
            c_st_error: begin
                if (w_clr_edge || w_ent_edge) begin
                    w_state_nxt = c_st_locked;
                end
            end

            // Counter runs LOCK_CYCLES-1 down to 0, so the state is held for
            // exactly LOCK_CYCLES cycles. All buttons are ignored meanwhile.
            c_st_lockout: begin
                if (r_lock_cnt == '0) begin
                    w_state_nxt = c_st_locked;
                    w_tries_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt - c_lck_w'(1);
                end
            end

            c_st_open: begin
                if (w_clr_edge) begin
                    w_state_nxt = c_st_locked;
                end else if (w_chg_edge) begin
                    w_state_nxt = c_st_set;
                    w_buf_nxt   = '0;
                    w_ptr_nxt   = '0;
                end
            end

            c_st_set: begin
                if (w_clr_edge) begin
                    w_state_nxt = c_st_open;
                    w_buf_nxt   = '0;
                    w_ptr_nxt   = '0;
                end else if (w_ent_edge) begin
                    if (r_ptr == c_ptr_last) begin
                        w_code_nxt  = w_buf_wr;
                        w_buf_nxt   = '0;
                        w_ptr_nxt   = '0;
                        w_state_nxt = c_st_locked;
                    end else begin
                        w_buf_nxt = w_buf_wr;
                        w_ptr_nxt = r_ptr + c_ptr_w'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_locked;
                w_buf_nxt   = '0;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Display refresh: r_idx advances every REFRESH_DIV cycles.
    //--------------------------------------------------------------------------
    logic [c_ref_w-1:0] r_ref_cnt;
    logic [c_idx_w-1:0] r_idx;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= '0;
        end else if (r_ref_cnt == c_ref_last) begin
            r_ref_cnt <= '0;
            r_idx     <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end else begin
            r_ref_cnt <= r_ref_cnt + c_ref_w'(1);
        end
    end

    //--------------------------------------------------------------------------
    // Output decode. Anode and segment data are both computed from the same
    // r_idx and registered together, so they switch in the same cycle.
    //--------------------------------------------------------------------------
    logic [DIGIT_W-1:0]  w_digit;
    logic [N_DIGITS-1:0] w_an;
    logic [6:0]          w_seg;
    logic [5:0]          w_led;

    always_comb begin
        w_digit = '0;
        for (int s = 0; s < N_DIGITS; s++) begin
            if (r_idx == c_idx_w'(s)) begin
                w_digit = r_buf[(N_DIGITS-1-s)*DIGIT_W +: DIGIT_W];
            end
        end

        // idx 0 (the MS slot) drives the highest anode.
        w_an = '1;
        for (int a = 0; a < N_DIGITS; a++) begin
            if (r_idx == c_idx_w'(N_DIGITS - 1 - a)) begin
                w_an[a] = 1'b0;
            end
        end

        case (r_state)
            c_st_locked, c_st_set: begin
                if (c_ptr_w'(r_idx) < r_ptr) begin
                    w_seg = f_hex_glyph(4'(w_digit));
                end else begin
                    w_seg = c_seg_blank;
                end
            end
            c_st_error, c_st_lockout: w_seg = c_seg_dash;
            default:                  w_seg = c_seg_blank;
        endcase

        w_led    = '0;
        w_led[0] = (r_state == c_st_locked);
        w_led[1] = (r_state == c_st_open);
        w_led[2] = (r_state == c_st_set);
        w_led[3] = (r_state == c_st_error);
        w_led[4] = (r_state == c_st_lockout);
        w_led[5] = (r_ptr != '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            led       <= 6'b000001;
            AN        <= '1;
            seven_out <= c_seg_blank;
        end else begin
            led       <= w_led;
            AN        <= w_an;
            seven_out <= w_seg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
//+----------------------------------------------------------------------------+
//| Module      : tb_code_lock_ctrl                                            |
//| Description : Directed self-checking bench for code_lock_ctrl. Instance A  |
//|               uses 4 hex digits, instance B uses 6 octal digits.           |
//| Revision    : 1.0 - initial release                                        |
//+----------------------------------------------------------------------------+
`default_nettype none

module tb_code_lock_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_DIGITS=4, DIGIT_W=4
    logic       a_rst, a_clr, a_ent, a_chg;
    logic [3:0] a_sw;
    logic [5:0] a_led;
    logic [3:0] a_an;
    logic [6:0] a_seg;

    // Instance B: N_DIGITS=6, DIGIT_W=3
    logic       b_rst, b_clr, b_ent, b_chg;
    logic [2:0] b_sw;
    logic [5:0] b_led;
    logic [5:0] b_an;
    logic [6:0] b_seg;

    code_lock_ctrl #(
        .N_DIGITS(4), .DIGIT_W(4), .RESET_CODE(16'h1234),
        .MAX_TRIES(3), .LOCK_CYCLES(20), .REFRESH_DIV(4)
    ) u_dut_a (
        .clk_in(clk), .rst(a_rst), .clr(a_clr), .ent(a_ent), .change(a_chg),
        .sw(a_sw), .led(a_led), .AN(a_an), .seven_out(a_seg)
    );

    code_lock_ctrl #(
        .N_DIGITS(6), .DIGIT_W(3), .RESET_CODE(18'o123456),
        .MAX_TRIES(3), .LOCK_CYCLES(20), .REFRESH_DIV(4)
    ) u_dut_b (
        .clk_in(clk), .rst(b_rst), .clr(b_clr), .ent(b_ent), .change(b_chg),
        .sw(b_sw), .led(b_led), .AN(b_an), .seven_out(b_seg)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_key(input logic [3:0] d);
        a_sw = d; a_ent = 1'b1; tick(1); a_ent = 1'b0; tick(3);
    endtask

    task automatic a_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) a_key(c[(15 - 4*i) -: 4]);
    endtask

    task automatic a_press_clr();
        a_clr = 1'b1; tick(1); a_clr = 1'b0; tick(3);
    endtask

    task automatic a_press_chg();
        a_chg = 1'b1; tick(1); a_chg = 1'b0; tick(3);
    endtask

    task automatic b_key(input logic [2:0] d);
        b_sw = d; b_ent = 1'b1; tick(1); b_ent = 1'b0; tick(3);
    endtask

    task automatic b_press_clr();
        b_clr = 1'b1; tick(1); b_clr = 1'b0; tick(3);
    endtask

    logic [3:0] exp_an, an_shift;
    logic [6:0] exp_seg;
    logic [3:0] prev_an;
    logic [5:0] prev_b_an;
    int         found, blank_bad, n_lock, last_lock, first_lkd;
    logic [6:0] lock_seg;

    initial begin
        a_rst = 1'b1; a_clr = 1'b0; a_ent = 1'b0; a_chg = 1'b0; a_sw = '0;
        b_rst = 1'b1; b_clr = 1'b0; b_ent = 1'b0; b_chg = 1'b0; b_sw = '0;
        tick(3);

        // Reset values
        check_val("a_rst_led", 32'(a_led), 32'b000001);
        check_val("a_rst_an",  32'(a_an),  32'hF);
        check_val("a_rst_seg", 32'(a_seg), 32'h7F);
        check_val("b_rst_an",  32'(b_an),  32'h3F);
        a_rst = 1'b0; b_rst = 1'b0;
        tick(1);
        check_val("a_first_anode", 32'(a_an), 32'b0111);

        // Correct code with final-digit latency: not open 2 cycles after the
        // sampling edge, open 3 cycles after it.
        a_key(4'd1); a_key(4'd2); a_key(4'd3);
        a_sw = 4'd4; a_ent = 1'b1; tick(1); a_ent = 1'b0;
        tick(2);
        check_val("a_open_early", 32'(a_led[1]), 32'd0);
        tick(1);
        check_val("a_open_led", 32'(a_led), 32'b000010);
        a_press_clr();
        check_val("a_relock", 32'(a_led), 32'b000001);

        // Mid-entry clear
        a_key(4'd1); a_key(4'd2);
        check_val("a_entry_led", 32'(a_led), 32'b100001);
        a_press_clr();
        check_val("a_clr_led", 32'(a_led), 32'b000001);
        blank_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_seg != 7'h7F) blank_bad++;
            tick(1);
        end
        check_val("a_clr_blank", 32'(blank_bad), 32'd0);

        // ent and clr edges in the same cycle: only the clear happens
        a_key(4'd1);
        a_sw = 4'd2; a_ent = 1'b1; a_clr = 1'b1; tick(1);
        a_ent = 1'b0; a_clr = 1'b0; tick(3);
        check_val("a_prio_led", 32'(a_led), 32'b000001);

        // Display after entering A,5
        a_key(4'hA); a_key(4'h5);
        found = 0; prev_an = a_an;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(1);
            if (a_an == 4'b0111 && prev_an != 4'b0111) found = 1;
            else prev_an = a_an;
        end
        check_val("a_disp_sync", 32'(found), 32'd1);
        for (int j = 0; j < 16; j++) begin
            an_shift = 4'b1000 >> (j / 4);
            exp_an   = ~an_shift;
            exp_seg  = (j < 4) ? 7'b0001000 : (j < 8) ? 7'b0010010 : 7'h7F;
            check_val("a_disp_an",  32'(a_an),  32'(exp_an));
            check_val("a_disp_seg", 32'(a_seg), 32'(exp_seg));
            tick(1);
        end
        a_press_clr();

        // Code change: abort during SET keeps old code
        a_code(16'h1234);
        check_val("a_open2", 32'(a_led), 32'b000010);
        a_press_chg();
        check_val("a_set_led", 32'(a_led), 32'b000100);
        a_key(4'd9); a_key(4'd8);
        a_press_clr();
        check_val("a_set_abort", 32'(a_led), 32'b000010);
        a_press_clr();
        a_code(16'h1234);
        check_val("a_code_kept", 32'(a_led), 32'b000010);

        // Code change to 9876
        a_press_chg();
        a_code(16'h9876);
        check_val("a_new_locked", 32'(a_led), 32'b000001);
        a_code(16'h1234);
        check_val("a_old_rejected", 32'(a_led), 32'b001000);
        check_val("a_err_dash", 32'(a_seg), 32'b0111111);
        a_press_clr();
        a_code(16'h9876);
        check_val("a_new_opens", 32'(a_led), 32'b000010);

        // Reset restores RESET_CODE
        a_rst = 1'b1; tick(1); a_rst = 1'b0; tick(1);
        check_val("a_rst_mid_led", 32'(a_led), 32'b000001);
        a_code(16'h1234);
        check_val("a_rst_code", 32'(a_led), 32'b000010);
        a_press_clr();

        // Three mismatches -> lockout for exactly 20 cycles
        a_code(16'h1111);
        check_val("a_err1", 32'(a_led), 32'b001000);
        a_press_clr();
        a_code(16'h1111);
        check_val("a_err2", 32'(a_led), 32'b001000);
        a_press_clr();
        a_key(4'd1); a_key(4'd1); a_key(4'd1);
        a_sw = 4'd1; a_ent = 1'b1; tick(1); a_ent = 1'b0;
        n_lock = 0; last_lock = -1; first_lkd = -1; lock_seg = '0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (a_led[4]) begin n_lock++; last_lock = i; end
            if (first_lkd < 0 && last_lock >= 0 && a_led[0]) first_lkd = i;
            if (i == 6) begin a_ent = 1'b1; a_clr = 1'b1; end
            if (i == 7) begin a_ent = 1'b0; a_clr = 1'b0; end
            if (i == 10) lock_seg = a_seg;
        end
        check_val("a_lockout_len",  32'(n_lock), 32'd20);
        check_val("a_lockout_rel",  32'(first_lkd - last_lock), 32'd1);
        check_val("a_lockout_dash", 32'(lock_seg), 32'b0111111);
        check_val("a_after_lockout", 32'(a_led), 32'b000001);

        // Reset clears the try counter
        a_code(16'h1111); a_press_clr();
        a_code(16'h1111); a_press_clr();
        a_rst = 1'b1; tick(1); a_rst = 1'b0; tick(1);
        a_code(16'h1111); a_press_clr();
        a_code(16'h1111);
        check_val("a_tries_rst", 32'(a_led), 32'b001000);

        // Instance B: 6 octal digits
        for (int i = 1; i <= 6; i++) b_key(3'(i));
        check_val("b_open", 32'(b_led), 32'b000010);
        b_press_clr();
        b_key(3'd7);
        check_val("b_entry_led", 32'(b_led), 32'b100001);
        found = 0; prev_b_an = b_an;
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick(1);
            if (b_an == 6'b011111 && prev_b_an != 6'b011111) found = 1;
            else prev_b_an = b_an;
        end
        check_val("b_disp_sync", 32'(found), 32'd1);
        check_val("b_disp7", 32'(b_seg), 32'b1111000);
        b_press_clr();

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 6; i++) b_key(3'd7);
            if (t < 2) b_press_clr();
        end
        check_val("b_lockout", 32'(b_led), 32'b010000);
        tick(5);
        b_rst = 1'b1; tick(1);
        check_val("b_rst_lockout", 32'(b_led), 32'b000001);
        check_val("b_rst_an2",     32'(b_an),  32'h3F);
        b_rst = 1'b0; tick(1);
        for (int i = 0; i < 6; i++) b_key(3'd7);
        check_val("b_tries0", 32'(b_led), 32'b001000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
